// File: rtl/bit_reversal_inv_stream.sv
// Streaming inverse of the 2^LOGN+1 bit-reversal/rotate permutation: scatter a frame in, drain it in natural order.
// Optional frame-length checking (s_last/err ports) is enabled by defining BITREV_INV_FRAMECHK_EN.
module bit_reversal_inv_stream #(
  parameter int WIDTH = 32,
  parameter int LOGN  = 8,
  parameter int SIZE  = 257
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       in_step,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
`ifdef BITREV_INV_FRAMECHK_EN
  ,
  input  logic             s_last,
  output logic             err
`endif
);

  localparam int AW = $clog2(SIZE);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t           state;
  logic [AW-1:0]    wr_cnt;
  logic [AW-1:0]    rd_cnt;
  logic [2:0]       step;
  logic [WIDTH-1:0] buffer [SIZE];

  logic [AW-1:0]    wr_addr;
  logic [LOGN-1:0]  q;
  logic [LOGN-1:0]  rot;
  logic [LOGN-1:0]  rev;
  int               rot_amt;
  logic             wr_en;
  logic             rd_en;

  // Beat 0 always lands at address 0; the rest go through rotate-right then bit-reverse of p-1.
  always_comb begin
    q       = LOGN'(wr_cnt - AW'(1));
    rot_amt = int'(step) % LOGN;
    rot     = LOGN'({q, q} >> rot_amt);
    rev     = '0;
    for (int i = 0; i < LOGN; i++) begin
      rev[i] = rot[LOGN-1-i];
    end
    wr_addr = (wr_cnt == '0) ? '0 : AW'(rev) + AW'(1);
  end

  assign wr_en = (state == LOAD) && s_valid && s_ready;
  assign rd_en = (state == DRAIN) && (!m_valid || m_ready) && (rd_cnt < AW'(SIZE));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer[wr_addr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= LOAD;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      step    <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (wr_en) begin
            if (wr_cnt == '0) begin
              step <= in_step;
            end
            if (wr_cnt == AW'(SIZE - 1)) begin
              wr_cnt  <= '0;
              state   <= DRAIN;
              s_ready <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        DRAIN: begin
          // The read doubles as the output register load, so a stalled sink freezes both.
          if (rd_en) begin
            m_data  <= buffer[rd_cnt];
            m_valid <= 1'b1;
            m_last  <= (rd_cnt == AW'(SIZE - 1));
            rd_cnt  <= rd_cnt + AW'(1);
          end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              rd_cnt  <= '0;
              state   <= LOAD;
              s_ready <= 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef BITREV_INV_FRAMECHK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (wr_en && (s_last != (wr_cnt == AW'(SIZE - 1)))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
